// File: rtl/avmm_page_arbiter_pkg.sv
// Shared types and width helpers for the paged Avalon-MM arbiter.
package avmm_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        K_READ  = 1'b0,
        K_WRITE = 1'b1
    } kind_t;

    // Burst counter width: must hold MAX_BURST itself without wrapping.
    function automatic int bcw_f(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // Page select width, never narrower than one bit.
    function automatic int pcw_f(input int page_count);
        return (page_count > 1) ? $clog2(page_count) : 1;
    endfunction

    // Master index width, never narrower than one bit.
    function automatic int idxw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avmm_page_arbiter_if.sv
// Bundle of the NM master-side ports and the single page-memory slave port.
// 'slave' is the arbiter's view (it is the slave of the masters and drives
// the page memory); 'master' is the environment's view of the same wires.
interface avmm_page_arbiter_if
    import avmm_arb_pkg::*;
#(
    parameter int NM         = 2,
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 8,
    parameter int PAGE_COUNT = 4
);
    localparam int BCW = bcw_f(MAX_BURST);
    localparam int PCW = pcw_f(PAGE_COUNT);

    // master side
    logic [NM-1:0][AW-1:0]   m_address;
    logic [NM-1:0]           m_read;
    logic [NM-1:0]           m_write;
    logic [NM-1:0][BCW-1:0]  m_burstcount;
    logic [NM-1:0][DW/8-1:0] m_byteenable;
    logic [NM-1:0][DW-1:0]   m_writedata;
    logic [NM-1:0][PCW-1:0]  m_page;
    logic [NM-1:0]           m_waitrequest;
    logic [DW-1:0]           m_readdata;
    logic [NM-1:0]           m_readdatavalid;

    // page memory side
    logic [AW-1:0]           s_address;
    logic                    s_read;
    logic                    s_write;
    logic [BCW-1:0]          s_burstcount;
    logic [DW/8-1:0]         s_byteenable;
    logic [DW-1:0]           s_writedata;
    logic                    s_waitrequest;
    logic [DW-1:0]           s_readdata;
    logic                    s_readdatavalid;
    logic [PCW-1:0]          page_number;

    modport slave (
        input  m_address, m_read, m_write, m_burstcount, m_byteenable, m_writedata, m_page,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output s_address, s_read, s_write, s_burstcount, s_byteenable, s_writedata, page_number,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport master (
        output m_address, m_read, m_write, m_burstcount, m_byteenable, m_writedata, m_page,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  s_address, s_read, s_write, s_burstcount, s_byteenable, s_writedata, page_number,
        output s_waitrequest, s_readdata, s_readdatavalid
    );

endinterface

// File: rtl/avmm_page_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping modulo NM) wins. Output is both one-hot and encoded.
module rr_pick
    import avmm_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = idxw_f(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);

    int          jj;
    logic [IW-1:0] j_idx;

    // Walk offsets from the far end back to zero so the closest requester to ptr is written last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        jj    = 0;
        j_idx = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            jj = int'(ptr) + k;
            if (jj >= NM) jj = jj - NM;
            j_idx = IW'(jj);
            if (req[j_idx]) begin
                gnt        = '0;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/avmm_page_arbiter.sv
// Shares one paged Avalon-MM slave between NM burst masters. Grant is
// registered (one IDLE cycle of arbitration) and held for a whole burst;
// the granted master's page select is captured at grant time.
module avmm_page_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NM         = 2,
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 8,
    parameter int PAGE_COUNT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    avmm_page_arbiter_if.slave  bus
);

    localparam int BCW = bcw_f(MAX_BURST);
    localparam int PCW = pcw_f(PAGE_COUNT);
    localparam int IW  = idxw_f(NM);

    state_t         state_q, state_d;
    kind_t          kind_q, kind_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [PCW-1:0] page_q, page_d;
    logic [BCW-1:0] len_q, len_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic           started_q, started_d;

    logic [NM-1:0]  req;
    logic [NM-1:0]  pick_gnt;
    logic [IW-1:0]  pick_idx;
    logic [BCW-1:0] g_bc;
    logic [BCW-1:0] first_len;
    logic [BCW-1:0] cnt_inc;
    logic [IW-1:0]  next_ptr;
    logic           g_rd, g_wr;

    assign req = bus.m_read | bus.m_write;

    rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign g_rd      = bus.m_read[grant_q];
    assign g_wr      = bus.m_write[grant_q];
    assign g_bc      = bus.m_burstcount[grant_q];
    assign first_len = (g_bc == '0) ? BCW'(1) : g_bc;
    assign cnt_inc   = cnt_q + BCW'(1);
    assign next_ptr  = (grant_q == IW'(NM - 1)) ? '0 : grant_q + IW'(1);

    assign bus.m_readdata  = bus.s_readdata;
    assign bus.page_number = page_q;

    // FSM state, grant, page and beat counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            kind_q    <= K_READ;
            grant_q   <= '0;
            ptr_q     <= '0;
            page_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            page_q    <= page_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
        end
    end

    // Next-state, command mux and per-master handshake.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        page_d    = page_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        started_d = started_q;

        bus.s_address       = '0;
        bus.s_read          = 1'b0;
        bus.s_write         = 1'b0;
        bus.s_burstcount    = '0;
        bus.s_byteenable    = '0;
        bus.s_writedata     = '0;
        bus.m_waitrequest   = '1;
        bus.m_readdatavalid = '0;

        case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    grant_d   = pick_idx;
                    page_d    = bus.m_page[pick_idx];
                    started_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                bus.s_address              = bus.m_address[grant_q];
                bus.s_burstcount           = g_bc;
                bus.s_byteenable           = bus.m_byteenable[grant_q];
                bus.s_writedata            = bus.m_writedata[grant_q];
                bus.m_waitrequest[grant_q] = bus.s_waitrequest;

                if (!started_q) begin
                    // Write wins when a master raises both strobes.
                    bus.s_write = g_wr;
                    bus.s_read  = g_rd & ~g_wr;
                    if (!(g_rd | g_wr)) begin
                        state_d = IDLE;
                    end else if (!bus.s_waitrequest) begin
                        started_d = 1'b1;
                        len_d     = first_len;
                        kind_d    = g_wr ? K_WRITE : K_READ;
                        cnt_d     = g_wr ? BCW'(1) : '0;
                        if (g_wr && first_len == BCW'(1)) begin
                            state_d = IDLE;
                            ptr_d   = next_ptr;
                        end
                    end
                end else if (kind_q == K_WRITE) begin
                    bus.s_write = g_wr;
                    if (g_wr && !bus.s_waitrequest) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = IDLE;
                            ptr_d   = next_ptr;
                        end
                    end
                end else begin
                    // Read command already issued; only count returning beats.
                    bus.m_readdatavalid[grant_q] = bus.s_readdatavalid;
                    if (bus.s_readdatavalid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = IDLE;
                            ptr_d   = next_ptr;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_avmm_page_arbiter.sv
// Bench for avmm_page_arbiter: master BFMs, a randomly stalling page-memory
// model, and a reference round-robin schedule built from the arbitration rules.
module tb_avmm_page_arbiter;

    localparam int NM = 3, AW = 16, DW = 64, MAX_BURST = 8, PAGE_COUNT = 4;
    localparam int BCW = 4, PCW = 2, LIM = 400;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    avmm_page_arbiter_if #(.NM(NM), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .PAGE_COUNT(PAGE_COUNT)) bus ();

    avmm_page_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .PAGE_COUNT(PAGE_COUNT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int             m;
        bit             wr;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        int             pg;
        int             bc;
    } beat_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        int            bc;
        int            pg;
        int            pg2;
    } txn_t;

    int    checks = 0, errors = 0;
    int    mptr = 0;
    int    pend = 0;
    int    stall_left = 0;
    bit    rnd_stall = 1'b0;
    int    rdv_cnt [NM];
    beat_t act_q[$];
    beat_t exp_all[$];
    txn_t  plan [NM][2];
    int    nplan [NM];

    // Bus monitor at negedge, then page-memory responses just after posedge.
    always begin : slave_model
        int    zeros, gi;
        beat_t b;
        @(negedge clock);
        if (reset_n) begin
            if ((bus.s_read || bus.s_write) && !bus.s_waitrequest) begin
                zeros = 0;
                gi = -1;
                for (int i = 0; i < NM; i++)
                    if (!bus.m_waitrequest[i]) begin zeros++; gi = i; end
                checks++;
                if (zeros != 1) begin
                    errors++;
                    $display("FAIL wait_onehot: m_waitrequest=%b, required exactly one 0", bus.m_waitrequest);
                end
                b.m  = gi;
                b.wr = bus.s_write;
                b.a  = bus.s_address;
                b.d  = bus.s_write ? bus.s_writedata : '0;
                b.pg = int'(bus.page_number);
                b.bc = int'(bus.s_burstcount);
                act_q.push_back(b);
                if (bus.s_read && !bus.s_write)
                    pend += (bus.s_burstcount == '0) ? 1 : int'(bus.s_burstcount);
            end
            if (bus.m_readdatavalid != '0) begin
                checks++;
                if ($countones(bus.m_readdatavalid) != 1 || !bus.s_readdatavalid ||
                    bus.m_readdata !== bus.s_readdata) begin
                    errors++;
                    $display("FAIL rdv_fwd: m_rdv=%b s_rdv=%b m_rd=%h s_rd=%h", bus.m_readdatavalid,
                             bus.s_readdatavalid, bus.m_readdata, bus.s_readdata);
                end
                for (int i = 0; i < NM; i++) if (bus.m_readdatavalid[i]) rdv_cnt[i]++;
            end
        end
        @(posedge clock);
        #1;
        if (stall_left > 0) begin
            bus.s_waitrequest = 1'b1;
            stall_left--;
        end else begin
            bus.s_waitrequest = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (pend > 0 && $urandom_range(0, 1) == 1) begin
            bus.s_readdatavalid = 1'b1;
            bus.s_readdata      = {$urandom, $urandom};
            pend--;
        end else begin
            bus.s_readdatavalid = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_plan;
        for (int m = 0; m < NM; m++) nplan[m] = 0;
    endtask

    task automatic add_txn(input int m, input bit wr, input int a, input int bc, input int pg, input int pg2);
        plan[m][nplan[m]].wr  = wr;
        plan[m][nplan[m]].a   = AW'(a);
        plan[m][nplan[m]].bc  = bc;
        plan[m][nplan[m]].pg  = pg;
        plan[m][nplan[m]].pg2 = pg2;
        nplan[m]++;
    endtask

    // One Avalon burst from master m; entered and left just after a posedge.
    task automatic bfm(input int m, input txn_t t);
        int    n, done, cyc;
        beat_t e;
        n = (t.bc == 0) ? 1 : t.bc;
        done = 0;
        cyc = 0;
        bus.m_address[m]    = t.a;
        bus.m_burstcount[m] = BCW'(t.bc);
        bus.m_page[m]       = PCW'(t.pg);
        bus.m_byteenable[m] = '1;
        e.m = m; e.wr = t.wr; e.a = t.a; e.pg = t.pg; e.bc = t.bc;
        if (t.wr) begin
            bus.m_writedata[m] = {$urandom, $urandom};
            bus.m_write[m] = 1'b1;
            while (done < n && cyc < LIM) begin
                @(negedge clock);
                cyc++;
                if (!bus.m_waitrequest[m]) begin
                    e.d = bus.m_writedata[m];
                    exp_all.push_back(e);
                    done++;
                    @(posedge clock);
                    #1;
                    if (done == 1 && t.pg2 >= 0) bus.m_page[m] = PCW'(t.pg2);
                    bus.m_writedata[m] = {$urandom, $urandom};
                end else begin
                    @(posedge clock);
                    #1;
                end
            end
            bus.m_write[m] = 1'b0;
        end else begin
            bus.m_read[m] = 1'b1;
            while (done == 0 && cyc < LIM) begin
                @(negedge clock);
                cyc++;
                if (!bus.m_waitrequest[m]) done = 1;
                @(posedge clock);
                #1;
            end
            bus.m_read[m] = 1'b0;
            e.d = '0;
            exp_all.push_back(e);
            done = 0;
            while (done < n && cyc < LIM) begin
                @(negedge clock);
                cyc++;
                if (bus.m_readdatavalid[m]) done++;
                @(posedge clock);
                #1;
            end
        end
        checks++;
        if (cyc >= LIM) begin
            errors++;
            $display("FAIL bfm_timeout: master %0d finished %0d of %0d beats", m, done, n);
        end
    endtask

    task automatic run_master(input int m);
        for (int i = 0; i < nplan[m]; i++) bfm(m, plan[m][i]);
    endtask

    // Runs the current plan with every master starting together, then checks
    // bus order, payloads and read returns against the round-robin schedule.
    task automatic run_round(input string name);
        int cnt [NM];
        int exp_rdv [NM];
        int exp_seq[$];
        int left, p, w, j, beats, cyc;
        txn_t t;
        left = 0;
        for (int m = 0; m < NM; m++) begin
            cnt[m] = nplan[m];
            left += nplan[m];
            rdv_cnt[m] = 0;
            exp_rdv[m] = 0;
            for (int i = 0; i < nplan[m]; i++)
                if (!plan[m][i].wr) exp_rdv[m] += (plan[m][i].bc == 0) ? 1 : plan[m][i].bc;
        end
        p = mptr;
        while (left > 0) begin
            w = -1;
            for (int k = 0; k < NM; k++) begin
                j = (p + k) % NM;
                if (w < 0 && cnt[j] > 0) w = j;
            end
            t = plan[w][nplan[w] - cnt[w]];
            beats = t.wr ? ((t.bc == 0) ? 1 : t.bc) : 1;
            for (int b = 0; b < beats; b++) exp_seq.push_back(w);
            cnt[w]--;
            left--;
            p = (w + 1) % NM;
        end
        mptr = p;
        act_q.delete();
        exp_all.delete();

        @(posedge clock);
        #1;
        fork
            run_master(0);
            run_master(1);
            run_master(2);
        join

        @(negedge clock);
        checks++;
        if (bus.m_waitrequest !== '1 || bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: wait=%b s_read=%b s_write=%b, required all-1/0/0", name,
                     bus.m_waitrequest, bus.s_read, bus.s_write);
        end
        checks++;
        if (act_q.size() != exp_seq.size()) begin
            errors++;
            $display("FAIL %s beat_count: got %0d required %0d", name, act_q.size(), exp_seq.size());
        end else begin
            foreach (act_q[i]) begin
                checks++;
                if (act_q[i].m != exp_seq[i]) begin
                    errors++;
                    $display("FAIL %s order[%0d]: master %0d required %0d", name, i, act_q[i].m, exp_seq[i]);
                end
            end
        end
        for (int m = 0; m < NM; m++) begin
            beat_t a[$];
            beat_t e[$];
            foreach (act_q[i]) if (act_q[i].m == m) a.push_back(act_q[i]);
            foreach (exp_all[i]) if (exp_all[i].m == m) e.push_back(exp_all[i]);
            checks++;
            if (a.size() != e.size()) begin
                errors++;
                $display("FAIL %s m%0d_beats: got %0d required %0d", name, m, a.size(), e.size());
            end else begin
                foreach (a[i]) begin
                    checks++;
                    if (a[i].wr !== e[i].wr || a[i].a !== e[i].a || a[i].d !== e[i].d ||
                        a[i].pg != e[i].pg || a[i].bc != e[i].bc) begin
                        errors++;
                        $display("FAIL %s m%0d_beat[%0d]: got wr=%0d a=%h d=%h pg=%0d bc=%0d required wr=%0d a=%h d=%h pg=%0d bc=%0d",
                                 name, m, i, a[i].wr, a[i].a, a[i].d, a[i].pg, a[i].bc,
                                 e[i].wr, e[i].a, e[i].d, e[i].pg, e[i].bc);
                    end
                end
            end
            checks++;
            if (rdv_cnt[m] != exp_rdv[m]) begin
                errors++;
                $display("FAIL %s m%0d_rdv: got %0d required %0d", name, m, rdv_cnt[m], exp_rdv[m]);
            end
        end
        cyc = 0;
        while (pend > 0 && cyc < LIM) begin
            @(negedge clock);
            cyc++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mptr = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.m_waitrequest !== '1 || bus.s_read !== 1'b0 || bus.s_write !== 1'b0 ||
            bus.page_number !== '0 || bus.m_readdatavalid !== '0 || bus.s_address !== '0) begin
            errors++;
            $display("FAIL reset_state: wait=%b rd=%b wr=%b page=%0d rdv=%b addr=%h", bus.m_waitrequest,
                     bus.s_read, bus.s_write, bus.page_number, bus.m_readdatavalid, bus.s_address);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mptr = 0;
    endtask

    task automatic test_single_write;
        clear_plan();
        add_txn(0, 1'b1, 16'h0010, 4, 2, -1);
        run_round("single_write");
    endtask

    task automatic test_two_masters;
        do_reset();
        clear_plan();
        add_txn(0, 1'b1, 16'h0100, 2, 0, -1);
        add_txn(0, 1'b1, 16'h0140, 3, 3, -1);
        add_txn(1, 1'b1, 16'h0200, 2, 1, -1);
        run_round("two_masters");
    endtask

    task automatic test_read_stall;
        clear_plan();
        add_txn(1, 1'b0, 16'h0300, 3, 2, -1);
        stall_left = 3;
        run_round("read_stall");
    endtask

    task automatic test_burst_edges;
        clear_plan();
        add_txn(0, 1'b1, 16'h0400, 0, 1, -1);
        add_txn(0, 1'b1, 16'h0408, 8, 3, -1);
        add_txn(2, 1'b0, 16'h0500, 8, 2, -1);
        run_round("burst_edges");
    endtask

    task automatic test_page_change;
        clear_plan();
        add_txn(0, 1'b1, 16'h0600, 4, 1, 3);
        run_round("page_change");
    endtask

    task automatic test_reset_midread;
        int cyc;
        bit seen;
        cyc = 0;
        seen = 1'b0;
        bus.m_address[1]    = 16'h0700;
        bus.m_burstcount[1] = BCW'(4);
        bus.m_page[1]       = PCW'(1);
        bus.m_read[1]       = 1'b1;
        while (!seen && cyc < LIM) begin
            @(negedge clock);
            cyc++;
            if (!bus.m_waitrequest[1]) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.m_read[1] = 1'b0;
        seen = 1'b0;
        while (!seen && cyc < LIM) begin
            @(negedge clock);
            cyc++;
            if (bus.m_readdatavalid[1]) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.page_number !== PCW'(1)) begin
            errors++;
            $display("FAIL midread_first_beat: seen=%0d page=%0d required seen=1 page=1", seen, bus.page_number);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.m_waitrequest !== '1 || bus.s_read !== 1'b0 || bus.s_write !== 1'b0 ||
            bus.page_number !== '0 || bus.m_readdatavalid !== '0) begin
            errors++;
            $display("FAIL reset_midread: wait=%b rd=%b wr=%b page=%0d rdv=%b, required all-1/0/0/0/0",
                     bus.m_waitrequest, bus.s_read, bus.s_write, bus.page_number, bus.m_readdatavalid);
        end
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (bus.m_readdatavalid !== '0) begin
                errors++;
                $display("FAIL rdv_in_reset: got %b required 0", bus.m_readdatavalid);
            end
        end
        #2;
        reset_n = 1'b1;
        mptr = 0;
        cyc = 0;
        while (pend > 0 && cyc < LIM) begin
            @(negedge clock);
            cyc++;
            checks++;
            if (bus.m_readdatavalid !== '0) begin
                errors++;
                $display("FAIL late_rdv: got %b required 0", bus.m_readdatavalid);
            end
        end
        checks++;
        if (pend > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", pend);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random;
        int k;
        rnd_stall = 1'b1;
        for (int r = 0; r < 8; r++) begin
            clear_plan();
            for (int m = 0; m < NM; m++)
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(1, 2);
                    for (int i = 0; i < k; i++)
                        add_txn(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 16'hFFFF)),
                                int'($urandom_range(0, MAX_BURST)), int'($urandom_range(0, PAGE_COUNT - 1)), -1);
                end
            if (nplan[0] + nplan[1] + nplan[2] == 0)
                add_txn(int'($urandom_range(0, NM - 1)), 1'b1, 16'h0800, 5, 2, -1);
            run_round("random");
        end
        rnd_stall = 1'b0;
    endtask

    initial begin
        bus.m_address       = '0;
        bus.m_read          = '0;
        bus.m_write         = '0;
        bus.m_burstcount    = '0;
        bus.m_byteenable    = '0;
        bus.m_writedata     = '0;
        bus.m_page          = '0;
        bus.s_waitrequest   = 1'b0;
        bus.s_readdata      = '0;
        bus.s_readdatavalid = 1'b0;
        for (int m = 0; m < NM; m++) begin
            rdv_cnt[m] = 0;
            nplan[m] = 0;
        end

        test_reset();
        test_single_write();
        test_two_masters();
        test_read_stall();
        test_burst_edges();
        test_page_change();
        test_reset_midread();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
